// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: FSM states, default constants and the
// IF/ID payload layout.
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD
  } fetch_state_e;

  localparam logic [31:0] NOP_DEFAULT      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // 65-bit IF/ID payload: instruction, fetch address + 4, valid flag
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

  // Force an address onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Ready/valid instruction-memory port: one request channel, one response
// channel, single outstanding transaction.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with flush > hold > load priority. When nothing is
// loaded and the stage is not held, a bubble is inserted.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush_i,
  input  logic  hold_i,
  input  logic  load_i,
  input  ifid_t data_i,
  output ifid_t data_o
);

  localparam ifid_t BUBBLE = '{instr: NOP, pc: 32'h0, valid: 1'b0};

  ifid_t data_q;

  // Output register: flush wins, then hold, otherwise load new data or a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= BUBBLE;
    end else if (flush_i) begin
      data_q <= BUBBLE;
    end else if (!hold_i) begin
      data_q <= load_i ? data_i : BUBBLE;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues one fetch at a time, buffers a
// response that arrives during a freeze, and kills in-flight fetches on a
// branch redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  if_stage_if.master        imem,
  output logic [31:0]       PC,
  output logic [31:0]       Instruction,
  output logic              inst_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  hold_word_q, hold_word_d;
  logic         kill_q, kill_d;
  logic         run_q;

  logic         accept;
  logic         out_load;
  logic [31:0]  seq_pc;
  ifid_t        out_data;
  ifid_t        ifid_q;

  // Requests depend only on registered state so there is no input-to-output path
  assign imem.imem_req  = run_q && (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;
  assign accept         = imem.imem_req && imem.imem_ready;
  assign seq_pc         = req_pc_q + PC_INCR;

  // State, PC, kill flag and hold buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      hold_word_q <= NOP;
      kill_q      <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      hold_word_q <= hold_word_d;
      kill_q      <= kill_d;
      run_q       <= 1'b1;
    end
  end

  // Next-state logic; a branch redirect overrides every other PC update
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    hold_word_d = hold_word_q;
    kill_d      = kill_q;
    out_load    = 1'b0;
    out_data    = '{instr: imem.imem_rdata, pc: seq_pc, valid: 1'b1};

    case (state_q)
      ST_FETCH: begin
        if (accept) begin
          state_d  = ST_WAIT;
          req_pc_d = pc_q;
          // an accept coinciding with a redirect fetches a now-dead address
          kill_d   = br_taken;
        end
      end
      ST_WAIT: begin
        if (imem.imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || br_taken) begin
            state_d = ST_FETCH;
          end else if (freeze) begin
            hold_word_d = imem.imem_rdata;
            state_d     = ST_HOLD;
          end else begin
            out_load = 1'b1;
            pc_d     = seq_pc;
            state_d  = ST_FETCH;
          end
        end else if (br_taken) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (br_taken) begin
          state_d = ST_FETCH;
        end else if (!freeze) begin
          out_load       = 1'b1;
          out_data.instr = hold_word_q;
          pc_d           = seq_pc;
          state_d        = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (br_taken) begin
      pc_d = align_word(br_target);
    end
  end

  if_id_reg #(
    .NOP (NOP)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (br_taken),
    .hold_i  (freeze),
    .load_i  (out_load),
    .data_i  (out_data),
    .data_o  (ifid_q)
  );

  assign Instruction = ifid_q.instr;
  assign PC          = ifid_q.pc;
  assign inst_valid  = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by random freeze/branch/
// memory-ready traffic, checked against a transaction-level reference model.
module tb_if_stage;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        freeze, br_taken;
  logic [31:0] br_target;
  logic [31:0] pc_o, instr_o, pc2_o, instr2_o;
  logic        valid_o, valid2_o;

  always #5 clk = ~clk;

  if_stage_if ifc ();
  if_stage_if ifc2 ();

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem        (ifc),
    .PC          (pc_o),
    .Instruction (instr_o),
    .inst_valid  (valid_o)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .rst         (rst2),
    .freeze      (1'b0),
    .br_taken    (1'b0),
    .br_target   (32'h0),
    .imem        (ifc2),
    .PC          (pc2_o),
    .Instruction (instr2_o),
    .inst_valid  (valid2_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: outstanding fetch, held word, next fetch address, outputs
  logic [31:0] m_inst, m_pc, m_next_pc, m_os_addr, m_held_word, m_held_addr;
  logic        m_valid, m_os, m_doomed, m_held, m_run;

  // Memory model: one pending response with a countdown
  logic        mem_pending;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0;
    m_next_pc = RESET_PC;
    m_os = 1'b0; m_doomed = 1'b0; m_held = 1'b0; m_run = 1'b0;
    m_os_addr = 32'h0; m_held_word = 32'h0; m_held_addr = 32'h0;
  endtask

  task automatic model_update(input logic f, input logic b, input logic [31:0] t,
                              input logic acc, input logic [31:0] acc_addr,
                              input logic rv, input logic [31:0] rd);
    logic        got, load;
    logic [31:0] lw, la;
    got = rv && m_os; load = 1'b0; lw = 32'h0; la = 32'h0;
    if (b) begin
      m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0;
      m_next_pc = t & 32'hFFFF_FFFC;
      m_held = 1'b0;
      if (got) begin
        m_os = 1'b0; m_doomed = 1'b0;
      end else if (m_os) begin
        m_doomed = 1'b1;
      end
    end else begin
      if (got) begin
        if (!m_doomed) begin
          if (f) begin
            m_held = 1'b1; m_held_word = rd; m_held_addr = m_os_addr;
          end else begin
            load = 1'b1; lw = rd; la = m_os_addr;
          end
        end
        m_os = 1'b0; m_doomed = 1'b0;
      end else if (m_held && !f) begin
        load = 1'b1; lw = m_held_word; la = m_held_addr; m_held = 1'b0;
      end
      if (load) begin
        m_inst = lw; m_pc = la + 32'd4; m_valid = 1'b1; m_next_pc = la + 32'd4;
      end else if (!f) begin
        m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0;
      end
    end
    if (acc) begin
      m_os = 1'b1; m_os_addr = acc_addr; m_doomed = b;
    end
    m_run = 1'b1;
  endtask

  // One clock cycle: called just after a falling edge, returns at the next one
  task automatic step(input logic f, input logic b, input logic [31:0] t, input logic rdy);
    logic        rv, exp_req, acc, mem_acc;
    logic [31:0] rd, acc_addr, mem_acc_addr;
    freeze = f; br_taken = b; br_target = t;
    rv = mem_pending && (mem_cnt == 0);
    rd = rv ? (32'h1111_0000 + mem_addr) : $urandom;
    ifc.imem_rvalid = rv; ifc.imem_rdata = rd; ifc.imem_ready = rdy;
    exp_req = m_run && !m_os && !m_held;
    chk("imem_req", 32'(ifc.imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", ifc.imem_addr, m_next_pc);
    acc = exp_req && rdy; acc_addr = m_next_pc;
    mem_acc = ifc.imem_req && rdy; mem_acc_addr = ifc.imem_addr;
    @(posedge clk); #1;
    model_update(f, b, t, acc, acc_addr, rv, rd);
    if (rv) mem_pending = 1'b0;
    else if (mem_pending && mem_cnt > 0) mem_cnt--;
    if (mem_acc) begin
      mem_pending = 1'b1; mem_addr = mem_acc_addr;
      mem_cnt = (mem_lat == 0) ? int'($urandom_range(0, 2)) : mem_lat - 1;
    end
    @(negedge clk);
    $display("step f=%0b br=%0b tgt=%h rdy=%0b rv=%0b -> instr=%h pc=%h v=%0b",
             f, b, t, rdy, rv, instr_o, pc_o, valid_o);
    chk("Instruction", instr_o, m_inst);
    chk("PC", pc_o, m_pc);
    chk("inst_valid", 32'(valid_o), 32'(m_valid));
  endtask

  // Idle cycles until nothing is in flight or buffered (bounded)
  task automatic drain();
    for (int i = 0; i < 20 && (m_os || m_held); i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_timeout", 32'(m_os || m_held), 32'h0);
  endtask

  logic [31:0] wrap_word;

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    freeze = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    ifc.imem_ready = 1'b0; ifc.imem_rvalid = 1'b0; ifc.imem_rdata = 32'h0;
    ifc2.imem_ready = 1'b0; ifc2.imem_rvalid = 1'b0; ifc2.imem_rdata = 32'h0;
    mem_pending = 1'b0; mem_addr = 32'h0; mem_cnt = 0; mem_lat = 1;
    model_reset();
    #2 rst = 1'b0; rst2 = 1'b0;
    #1;
    chk("rst_Instruction", instr_o, NOP);
    chk("rst_PC", pc_o, 32'h0);
    chk("rst_inst_valid", 32'(valid_o), 32'h0);
    chk("rst_imem_req", 32'(ifc.imem_req), 32'h0);
    chk("rst_wrap_req", 32'(ifc2.imem_req), 32'h0);

    // PC wrap on a second instance with RESET_PC at the top of the address space
    ifc2.imem_ready = 1'b1;
    @(negedge clk); rst2 = 1'b1;
    @(negedge clk);
    chk("wrap_req", 32'(ifc2.imem_req), 32'h1);
    chk("wrap_addr", ifc2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_req_in_wait", 32'(ifc2.imem_req), 32'h0);
    wrap_word = 32'h1111_0000 + 32'hFFFF_FFFC;
    ifc2.imem_rvalid = 1'b1; ifc2.imem_rdata = wrap_word;
    @(negedge clk);
    ifc2.imem_rvalid = 1'b0; ifc2.imem_ready = 1'b0;
    $display("wrap -> instr=%h pc=%h v=%0b addr=%h", instr2_o, pc2_o, valid2_o, ifc2.imem_addr);
    chk("wrap_Instruction", instr2_o, 32'h1110_FFFC);
    chk("wrap_PC", pc2_o, 32'h0);
    chk("wrap_valid", 32'(valid2_o), 32'h1);
    chk("wrap_next_req", 32'(ifc2.imem_req), 32'h1);
    chk("wrap_next_addr", ifc2.imem_addr, 32'h0);

    // Zero-wait sequential fetch: 0,4,8 with bubbles between
    model_reset();
    @(negedge clk); rst = 1'b1;
    mem_lat = 1;
    repeat (7) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Freeze across a response: word is held, released once freeze drops
    drain(); mem_lat = 2;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Branch while waiting: late response is dropped, refetch from 0x100
    drain(); mem_lat = 4;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Branch together with freeze while a word is held
    drain(); mem_lat = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Branch on the same cycle as an accept, unaligned target
    drain();
    step(1'b0, 1'b1, 32'h0000_0303, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset while waiting, late response after release must be ignored
    drain(); mem_lat = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    rst = 1'b0; ifc.imem_rvalid = 1'b0;
    #1;
    chk("midrst_Instruction", instr_o, NOP);
    chk("midrst_PC", pc_o, 32'h0);
    chk("midrst_valid", 32'(valid_o), 32'h0);
    chk("midrst_req", 32'(ifc.imem_req), 32'h0);
    model_reset();
    @(negedge clk);
    chk("midrst_req_held", 32'(ifc.imem_req), 32'h0);
    mem_cnt = 0;
    rst = 1'b1;
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic
    mem_lat = 0;
    repeat (400) step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                      $urandom, $urandom_range(0, 9) < 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and fetches one instruction at a time from a ready/valid instruction memory. It presents the instruction and the PC+4 value to the decode stage through its own IF/ID output register. It honours hazard freeze and branch redirect, and inserts NOP bubbles on flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset
- NOP, 32'h0000_0000, instruction word emitted as a bubble

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hazard stall; output register and PC hold
- br_taken  in  1  branch/jump taken, from decode
- br_target  in  32  redirect address, valid while br_taken=1
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned, stable while imem_req=1
- imem_ready  in  1  memory accepts request (imem_req & imem_ready = accept)
- imem_rvalid  in  1  response valid, exactly one per accept, ≥1 cycle after accept
- imem_rdata  in  32  instruction word
- PC  out  32  fetch address + 4 of the presented instruction
- Instruction  out  32  instruction to decode
- inst_valid  out  1  Instruction/PC hold a real instruction

## Operation
- State machine:
  - FETCH: imem_req=1, imem_addr=pc. On accept, go to WAIT and latch req_pc=pc.
  - WAIT: on imem_rvalid, capture the word.
  - HOLD: the received word is buffered because freeze=1. It moves out when freeze drops.
- Capture, when not frozen and not killed:
  - Instruction ← imem_rdata
  - PC ← req_pc+4
  - inst_valid ← 1
  - pc ← req_pc+4
  - go to FETCH
- When frozen on rvalid: store the word in the hold buffer, go to HOLD. The output register is unchanged.
- Between captures, with no freeze: the output register loads NOP with inst_valid=0. A bubble is emitted every cycle with no new instruction.
- With freeze=1: the output register and pc hold in every state.
- br_taken=1 (priority over freeze):
  - Output register ← NOP, PC ← 0, inst_valid ← 0.
  - pc ← br_target.
  - Any held word is discarded.
  - In FETCH: the next cycle requests br_target. A same-cycle accept of the old address is treated as in-flight, so kill is set.
  - In WAIT with no rvalid: set kill. The next rvalid is dropped and the state goes to FETCH.
  - In WAIT with rvalid in the same cycle: drop the word and go to FETCH.
  - In HOLD: go to FETCH.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0. The low two bits of br_target are forced to 0.

## Timing
- Reset (rst=0, asynchronous):
  - State → FETCH, pc=RESET_PC, kill=0.
  - Instruction=NOP, PC=0, inst_valid=0.
  - imem_req=0 while in reset. It goes to 1 the first cycle after deassertion.
- imem_req is decoded from state only; imem_addr comes from the pc register. Neither has a combinational path from the inputs.
- Latency: imem_rvalid at edge N makes Instruction/inst_valid visible after edge N.
- Throughput is at most 1 instruction per 2 cycles, with single outstanding request and zero-wait memory.
- br_taken at edge N gives inst_valid=0 after edge N. imem_addr=br_target follows at the latest in the first FETCH cycle after any killed response.
- Freeze release from HOLD at edge N: the held word is presented after edge N and the state goes to FETCH.
- Reset mid-WAIT: any later rvalid is ignored until the first post-reset accept.

## Structure
- Shared pipeline_pkg holds:
  - fetch-state enum (FETCH, WAIT, HOLD)
  - NOP and RESET_PC defaults
  - the PC increment constant 4
- One natural sub-module is if_id_reg: a 65-bit output register with hold (freeze), flush (br_taken) and load. It is reused between the other stages.
- The FSM, pc register, kill flag and hold buffer stay in if_stage.

## Test plan
- Reset release, memory with zero wait returning 32'h1111_0000+addr → imem_addr sequence 0,4,8. Instruction 32'h1111_0000 with PC=4, then 32'h1111_0004 with PC=8, a bubble between each.
- freeze=1 for 5 cycles, asserted while in WAIT, rvalid arriving during the freeze → the word is held and the outputs are unchanged. It appears the cycle after freeze=0, and no extra request is issued.
- br_taken with br_target=32'h0000_0100 while in WAIT, rvalid 3 cycles later → that word is never presented. The next imem_addr is 0x100, and the first valid PC is 0x104.
- br_taken and freeze asserted together in HOLD → a NOP bubble is presented, the held word is discarded, and the next fetch is br_target.
- RESET_PC=32'hFFFF_FFFC → the first fetch returns PC=0 and the next imem_addr=0 (wrap).
- rst asserted in WAIT with a late rvalid → outputs are at reset values and the late response is ignored. The first fetch after release is RESET_PC.
